// File: rtl/cpu_run_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_sequencer_if
// Purpose  : Control/status bundle between the boot/run sequencer and
//            whatever drives it (test harness, host block).
// Signals  : start      - single-cycle run request
//            run_limit  - run budget in cycles (0 = unlimited)
//            halt_req   - end RUN at the next edge
//            sys_rst    - active-high system reset
//            cpu_rst    - active-high per-channel CPU reset
//            running    - high while the cores run
//            done       - high once the run has finished
//            cycle_cnt  - RUN cycles elapsed
// Modports : master (requester side), slave (sequencer side)
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_run_sequencer_if #(
    parameter int NUM_CH = 1,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [CNT_W-1:0]  run_limit;
    logic              halt_req;
    logic              sys_rst;
    logic [NUM_CH-1:0] cpu_rst;
    logic              running;
    logic              done;
    logic [CNT_W-1:0]  cycle_cnt;

    modport master (
        output start, run_limit, halt_req,
        input  sys_rst, cpu_rst, running, done, cycle_cnt
    );

    modport slave (
        input  start, run_limit, halt_req,
        output sys_rst, cpu_rst, running, done, cycle_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cpu_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_sequencer
// Purpose  : Boot/run controller for the pipelined CPU. On start it drives a
//            system-reset phase, a settle gap and a CPU-reset phase, then runs
//            the cores for a programmable budget (or until halted) and flags
//            completion. All outputs are registered.
// Ports    : SysCLK - clock, rising edge
//            RST    - synchronous active-high reset
//            bus    - cpu_run_sequencer_if.slave (start, run_limit, halt_req,
//                     sys_rst, cpu_rst, running, done, cycle_cnt)
// Options  : STAGGER_RELEASE_EN - when defined, channel i leaves CPU reset
//            i*STAGGER_CYC cycles after channel 0; otherwise all channels
//            are released together.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_sequencer #(
    parameter int SYS_RST_CYC = 6,
    parameter int SETTLE_CYC  = 10,
    parameter int CPU_RST_CYC = 8,
    parameter int NUM_CH      = 1,
    parameter int STAGGER_CYC = 2,
    parameter int CNT_W       = 16
) (
    input  wire                SysCLK,
    input  wire                RST,
    cpu_run_sequencer_if.slave bus
);
    // Phase counter must reach the value at which CPU_RST hands over to RUN.
    localparam int c_CPU_SPAN = CPU_RST_CYC + (NUM_CH - 1) * STAGGER_CYC;
    localparam int c_PH_MAX0  = (SYS_RST_CYC > SETTLE_CYC) ? SYS_RST_CYC : SETTLE_CYC;
    localparam int c_PH_MAX   = (c_PH_MAX0 > c_CPU_SPAN) ? c_PH_MAX0 : c_CPU_SPAN;
    localparam int c_PH_W     = $clog2(c_PH_MAX + 1);

    localparam logic [c_PH_W-1:0] c_SYS_LAST    = c_PH_W'(SYS_RST_CYC - 1);
    localparam logic [c_PH_W-1:0] c_SETTLE_LAST = c_PH_W'(SETTLE_CYC - 1);
    // RUN begins one edge after the last channel has been released.
`ifdef STAGGER_RELEASE_EN
    localparam logic [c_PH_W-1:0] c_RUN_AT = c_PH_W'(c_CPU_SPAN);
`else
    localparam logic [c_PH_W-1:0] c_RUN_AT = c_PH_W'(CPU_RST_CYC);
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYS_RST = 3'd1,
        S_SETTLE  = 3'd2,
        S_CPU_RST = 3'd3,
        S_RUN     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            r_state;
    logic [c_PH_W-1:0] r_phase;
    logic [CNT_W-1:0]  r_limit;
    logic              r_sysRst;
    logic [NUM_CH-1:0] r_cpuRst;
    logic              r_running;
    logic              r_done;
    logic [CNT_W-1:0]  r_cycleCnt;

    state_t            w_stateNext;
    logic [c_PH_W-1:0] w_phaseNext;
    logic [CNT_W-1:0]  w_limitNext;
    logic              w_sysRstNext;
    logic [NUM_CH-1:0] w_cpuRstNext;
    logic              w_runningNext;
    logic              w_doneNext;
    logic [CNT_W-1:0]  w_cntNext;
    logic [CNT_W:0]    w_cntInc;
    logic [CNT_W-1:0]  w_cntSat;
    logic              w_limitHit;

    always_ff @(posedge SysCLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_limit    <= '0;
            r_sysRst   <= 1'b1;
            r_cpuRst   <= '1;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_cycleCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_phase    <= w_phaseNext;
            r_limit    <= w_limitNext;
            r_sysRst   <= w_sysRstNext;
            r_cpuRst   <= w_cpuRstNext;
            r_running  <= w_runningNext;
            r_done     <= w_doneNext;
            r_cycleCnt <= w_cntNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_phaseNext   = r_phase;
        w_limitNext   = r_limit;
        w_sysRstNext  = r_sysRst;
        w_cpuRstNext  = r_cpuRst;
        w_runningNext = r_running;
        w_doneNext    = r_done;
        w_cntNext     = r_cycleCnt;

        // One extra bit so a saturated counter can never alias a limit match.
        w_cntInc   = {1'b0, r_cycleCnt} + 1'b1;
        w_cntSat   = (&r_cycleCnt) ? r_cycleCnt : w_cntInc[CNT_W-1:0];
        w_limitHit = (r_limit != '0) && (w_cntInc == {1'b0, r_limit});

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_stateNext  = S_SYS_RST;
                    w_phaseNext  = '0;
                    w_limitNext  = bus.run_limit;
                    w_sysRstNext = 1'b1;
                    w_cpuRstNext = '1;
                    w_doneNext   = 1'b0;
                end
            end
            S_SYS_RST: begin
                if (r_phase == c_SYS_LAST) begin
                    w_stateNext  = S_SETTLE;
                    w_phaseNext  = '0;
                    w_sysRstNext = 1'b0;
                end else begin
                    w_phaseNext = r_phase + 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_phase == c_SETTLE_LAST) begin
                    w_stateNext = S_CPU_RST;
                    w_phaseNext = '0;
                end else begin
                    w_phaseNext = r_phase + 1'b1;
                end
            end
            S_CPU_RST: begin
                // Released bits stay low because the default is hold.
`ifdef STAGGER_RELEASE_EN
                for (int i = 0; i < NUM_CH; i++) begin
                    if (r_phase == c_PH_W'(CPU_RST_CYC - 1 + i * STAGGER_CYC))
                        w_cpuRstNext[i] = 1'b0;
                end
`else
                if (r_phase == c_PH_W'(CPU_RST_CYC - 1))
                    w_cpuRstNext = '0;
`endif
                if (r_phase == c_RUN_AT) begin
                    w_stateNext   = S_RUN;
                    w_phaseNext   = '0;
                    w_runningNext = 1'b1;
                    w_cntNext     = '0;
                end else begin
                    w_phaseNext = r_phase + 1'b1;
                end
            end
            S_RUN: begin
                w_cntNext = w_cntSat;
                if (bus.halt_req || w_limitHit) begin
                    w_stateNext   = S_DONE;
                    w_runningNext = 1'b0;
                    w_doneNext    = 1'b1;
                    w_cpuRstNext  = '1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    assign bus.sys_rst   = r_sysRst;
    assign bus.cpu_rst   = r_cpuRst;
    assign bus.running   = r_running;
    assign bus.done      = r_done;
    assign bus.cycle_cnt = r_cycleCnt;
endmodule
`default_nettype wire

// File: tb/tb_cpu_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_sequencer
// Purpose  : Self-checking bench for cpu_run_sequencer. Three instances:
//            d0 defaults (1 channel), d1 four channels, d2 4-bit counter.
//            Stimulus queues expected output snapshots; a monitor compares
//            one snapshot whenever an instance's control outputs change or a
//            probe is requested.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_sequencer;
    logic SysCLK;
    logic rst0, rst1, rst2;
    int   cyc;
    int   nCmp;
    int   nBad;
    bit   monEn;
    bit   probe [3];

    typedef struct {
        int         dut;
        int         cyc;
        logic       sys;
        logic [7:0] cpu;
        logic       run;
        logic       dn;
        int         cnt;
    } ev_t;

    ev_t expQ [$];

    cpu_run_sequencer_if #(.NUM_CH(1), .CNT_W(16)) b0 ();
    cpu_run_sequencer_if #(.NUM_CH(4), .CNT_W(16)) b1 ();
    cpu_run_sequencer_if #(.NUM_CH(1), .CNT_W(4))  b2 ();

    cpu_run_sequencer #(.NUM_CH(1), .CNT_W(16)) u0 (.SysCLK(SysCLK), .RST(rst0), .bus(b0));
    cpu_run_sequencer #(.NUM_CH(4), .STAGGER_CYC(2), .CNT_W(16)) u1 (.SysCLK(SysCLK), .RST(rst1), .bus(b1));
    cpu_run_sequencer #(.NUM_CH(1), .CNT_W(4))  u2 (.SysCLK(SysCLK), .RST(rst2), .bus(b2));

    initial begin
        SysCLK = 1'b0;
        forever #5 SysCLK = ~SysCLK;
    end

    always @(posedge SysCLK) cyc <= cyc + 1;

    function automatic ev_t mkEv(int d, int c, logic s, logic [7:0] cp, logic r, logic dn, int cnt);
        ev_t e;
        e.dut = d; e.cyc = c; e.sys = s; e.cpu = cp; e.run = r; e.dn = dn; e.cnt = cnt;
        return e;
    endfunction

    task automatic ex(int d, int c, logic s, logic [7:0] cp, logic r, logic dn, int cnt);
        expQ.push_back(mkEv(d, c, s, cp, r, dn, cnt));
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        ev_t cur [3];
        ev_t prv [3];
        ev_t e;
        bit  primed;
        bit  chg;
        primed = 1'b0;
        forever begin
            @(negedge SysCLK);
            if (monEn) begin
                cur[0] = mkEv(0, cyc, b0.sys_rst, 8'(b0.cpu_rst), b0.running, b0.done, 32'(b0.cycle_cnt));
                cur[1] = mkEv(1, cyc, b1.sys_rst, 8'(b1.cpu_rst), b1.running, b1.done, 32'(b1.cycle_cnt));
                cur[2] = mkEv(2, cyc, b2.sys_rst, 8'(b2.cpu_rst), b2.running, b2.done, 32'(b2.cycle_cnt));
                for (int d = 0; d < 3; d++) begin
                    chg = primed && ((cur[d].sys !== prv[d].sys) || (cur[d].cpu !== prv[d].cpu) ||
                                     (cur[d].run !== prv[d].run) || (cur[d].dn !== prv[d].dn));
                    if (chg || probe[d]) begin
                        probe[d] = 1'b0;
                        nCmp++;
                        if (expQ.size() == 0) begin
                            nBad++;
                            $display("FAIL unexpected_event dut%0d cyc=%0d got sys=%b cpu=%h run=%b done=%b cnt=%0d, none expected",
                                     d, cur[d].cyc, cur[d].sys, cur[d].cpu, cur[d].run, cur[d].dn, cur[d].cnt);
                        end else begin
                            e = expQ.pop_front();
                            if (e.dut != d || e.cyc != cur[d].cyc || e.sys !== cur[d].sys || e.cpu !== cur[d].cpu ||
                                e.run !== cur[d].run || e.dn !== cur[d].dn || e.cnt != cur[d].cnt) begin
                                nBad++;
                                $display("FAIL event dut%0d got cyc=%0d sys=%b cpu=%h run=%b done=%b cnt=%0d; want dut%0d cyc=%0d sys=%b cpu=%h run=%b done=%b cnt=%0d",
                                         d, cur[d].cyc, cur[d].sys, cur[d].cpu, cur[d].run, cur[d].dn, cur[d].cnt,
                                         e.dut, e.cyc, e.sys, e.cpu, e.run, e.dn, e.cnt);
                            end
                        end
                    end
                    prv[d] = cur[d];
                end
                primed = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge SysCLK);
        #1;
    endtask

    task automatic waitUntil(int c);
        while (cyc < c) tick();
    endtask

    task automatic drain(string name, int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (expQ.size() != 0) begin
            nCmp++;
            nBad++;
            $display("FAIL timeout_%s pending=%0d, want 0 within %0d cycles", name, expQ.size(), budget);
            expQ.delete();
        end
    endtask

    task automatic doStart(int d, int lim, output int e0);
        case (d)
            0:       begin b0.start = 1'b1; b0.run_limit = 16'(lim); end
            1:       begin b1.start = 1'b1; b1.run_limit = 16'(lim); end
            default: begin b2.start = 1'b1; b2.run_limit = 4'(lim); end
        endcase
        e0 = cyc + 1;
        tick();
        b0.start = 1'b0;
        b1.start = 1'b0;
        b2.start = 1'b0;
    endtask

    task automatic doProbe(int d, logic s, logic [7:0] cp, logic r, logic dn, int cnt);
        ex(d, cyc, s, cp, r, dn, cnt);
        probe[d] = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int e;
        int c;
        nCmp = 0; nBad = 0; monEn = 1'b0;
        probe[0] = 1'b0; probe[1] = 1'b0; probe[2] = 1'b0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        b0.start = 1'b0; b0.run_limit = '0; b0.halt_req = 1'b0;
        b1.start = 1'b0; b1.run_limit = '0; b1.halt_req = 1'b0;
        b2.start = 1'b0; b2.run_limit = '0; b2.halt_req = 1'b0;
        cyc = 0;
        repeat (3) tick();
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        monEn = 1'b1;

        // Reset state of every instance
        doProbe(0, 1'b1, 8'h01, 1'b0, 1'b0, 0);
        doProbe(1, 1'b1, 8'h0F, 1'b0, 1'b0, 0);
        doProbe(2, 1'b1, 8'h01, 1'b0, 1'b0, 0);
        drain("reset", 5);

        // Full sequence with a 150-cycle budget
        doStart(0, 150, e);
        ex(0, e + 6,   1'b0, 8'h01, 1'b0, 1'b0, 0);
        ex(0, e + 24,  1'b0, 8'h00, 1'b0, 1'b0, 0);
        ex(0, e + 25,  1'b0, 8'h00, 1'b1, 1'b0, 0);
        ex(0, e + 175, 1'b0, 8'h01, 1'b0, 1'b1, 150);
        drain("limit150", 250);

        // Unlimited run halted 40 cycles in, restarted from DONE
        doStart(0, 0, e);
        ex(0, e,      1'b1, 8'h01, 1'b0, 1'b0, 150);
        ex(0, e + 6,  1'b0, 8'h01, 1'b0, 1'b0, 150);
        ex(0, e + 24, 1'b0, 8'h00, 1'b0, 1'b0, 150);
        ex(0, e + 25, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        ex(0, e + 65, 1'b0, 8'h01, 1'b0, 1'b1, 40);
        waitUntil(e + 64);
        b0.halt_req = 1'b1;
        tick();
        b0.halt_req = 1'b0;
        drain("halt", 20);
        waitUntil(cyc + 10);
        doProbe(0, 1'b0, 8'h01, 1'b0, 1'b1, 40);
        drain("halt_frozen", 5);

        // start during RUN is ignored; later start from DONE takes new limit
        doStart(0, 20, e);
        ex(0, e,      1'b1, 8'h01, 1'b0, 1'b0, 40);
        ex(0, e + 6,  1'b0, 8'h01, 1'b0, 1'b0, 40);
        ex(0, e + 24, 1'b0, 8'h00, 1'b0, 1'b0, 40);
        ex(0, e + 25, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        ex(0, e + 45, 1'b0, 8'h01, 1'b0, 1'b1, 20);
        waitUntil(e + 30);
        b0.start = 1'b1;
        b0.run_limit = 16'd3;
        tick();
        b0.start = 1'b0;
        drain("start_in_run", 60);
        doStart(0, 5, e);
        ex(0, e,      1'b1, 8'h01, 1'b0, 1'b0, 20);
        ex(0, e + 6,  1'b0, 8'h01, 1'b0, 1'b0, 20);
        ex(0, e + 24, 1'b0, 8'h00, 1'b0, 1'b0, 20);
        ex(0, e + 25, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        ex(0, e + 30, 1'b0, 8'h01, 1'b0, 1'b1, 5);
        drain("restart5", 60);

        // RST during CPU_RST
        doStart(0, 10, e);
        ex(0, e,      1'b1, 8'h01, 1'b0, 1'b0, 5);
        ex(0, e + 6,  1'b0, 8'h01, 1'b0, 1'b0, 5);
        ex(0, e + 20, 1'b1, 8'h01, 1'b0, 1'b0, 0);
        waitUntil(e + 19);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        drain("rst_cpu_rst", 10);
        waitUntil(cyc + 5);
        doProbe(0, 1'b1, 8'h01, 1'b0, 1'b0, 0);
        drain("rst_idle", 5);

        // RST during RUN
        doStart(0, 0, e);
        ex(0, e + 6,  1'b0, 8'h01, 1'b0, 1'b0, 0);
        ex(0, e + 24, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        ex(0, e + 25, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        ex(0, e + 30, 1'b1, 8'h01, 1'b0, 1'b0, 0);
        waitUntil(e + 29);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        drain("rst_run", 40);

        // Four channels
        doStart(1, 3, e);
        ex(1, e + 6,  1'b0, 8'h0F, 1'b0, 1'b0, 0);
`ifdef STAGGER_RELEASE_EN
        ex(1, e + 24, 1'b0, 8'h0E, 1'b0, 1'b0, 0);
        ex(1, e + 26, 1'b0, 8'h0C, 1'b0, 1'b0, 0);
        ex(1, e + 28, 1'b0, 8'h08, 1'b0, 1'b0, 0);
        ex(1, e + 30, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        ex(1, e + 31, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        ex(1, e + 34, 1'b0, 8'h0F, 1'b0, 1'b1, 3);
`else
        ex(1, e + 24, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        ex(1, e + 25, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        ex(1, e + 28, 1'b0, 8'h0F, 1'b0, 1'b1, 3);
`endif
        drain("four_ch", 60);

        // 4-bit counter: saturation with unlimited budget
        doStart(2, 0, e);
        ex(2, e + 6,  1'b0, 8'h01, 1'b0, 1'b0, 0);
        ex(2, e + 24, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        ex(2, e + 25, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        drain("sat_enter", 40);
        waitUntil(e + 35);
        doProbe(2, 1'b0, 8'h00, 1'b1, 1'b0, 10);
        drain("sat_mid", 5);
        waitUntil(e + 65);
        doProbe(2, 1'b0, 8'h00, 1'b1, 1'b0, 15);
        drain("sat_hold", 5);
        c = cyc;
        ex(2, c + 1, 1'b1, 8'h01, 1'b0, 1'b0, 0);
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        drain("sat_rst", 5);

        // 4-bit counter: budget at the counter's maximum, then budget of 1
        doStart(2, 15, e);
        ex(2, e + 6,  1'b0, 8'h01, 1'b0, 1'b0, 0);
        ex(2, e + 24, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        ex(2, e + 25, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        ex(2, e + 40, 1'b0, 8'h01, 1'b0, 1'b1, 15);
        drain("limit15", 60);
        doStart(2, 1, e);
        ex(2, e,      1'b1, 8'h01, 1'b0, 1'b0, 15);
        ex(2, e + 6,  1'b0, 8'h01, 1'b0, 1'b0, 15);
        ex(2, e + 24, 1'b0, 8'h00, 1'b0, 1'b0, 15);
        ex(2, e + 25, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        ex(2, e + 26, 1'b0, 8'h01, 1'b0, 1'b1, 1);
        drain("limit1", 40);

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time exceeded, want completion before 200000");
        $fatal(1);
    end
endmodule
`default_nettype wire
